// File: rtl/ctrl_pkg.sv
// Shared control-frame definitions used by ctrl_tx and ctrl_rx:
// parser state encoding, frame length and default EtherTypes.
package ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,   // waiting for beat0 (src MAC, dest MAC high)
      ST_HDR     = 2'd1,   // waiting for beat1 (dest MAC low, type, slot)
      ST_PAYLOAD = 2'd2,   // beats 2..7, timestamp payload
      ST_DROP    = 2'd3    // discard until tlast
   } ctrl_state_e;

   localparam int unsigned FRAME_BEATS    = 8;
   localparam logic [15:0] SLOT_ID_TYPE   = 16'hff03;
   localparam logic [15:0] SIM_START_TYPE = 16'hff0a;
   localparam logic [7:0]  KEEP_ALL       = 8'hff;

endpackage

// File: rtl/ctrl_rx.sv
// Control-frame receiver: parses 8-beat slot-ID / sim-start frames from an
// AXI-Stream without backpressure and publishes the last valid frame.
// Optional feature macro: CTRL_RX_DELAY_EN (builds the one-way delay
// subtractor; otherwise o_delay is tied to zero).
module ctrl_rx
   import ctrl_pkg::*;
#(
   parameter logic [15:0] P_SLOT_ID_TYPE = SLOT_ID_TYPE,
   parameter logic [15:0] P_SIM_START    = SIM_START_TYPE,
   parameter logic [47:0] P_MY_MAC       = 48'h8D_BC_5C_4A_00_00
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_rx_axis_tvalid,
   input  logic [63:0] i_rx_axis_tdata,
   input  logic        i_rx_axis_tlast,
   input  logic [7:0]  i_rx_axis_tkeep,
   input  logic        i_rx_axis_tuser,
   input  logic [63:0] i_local_time,
   output logic        o_new_slot_start,
   output logic        o_sim_start,
   output logic        o_slot_id,
   output logic [47:0] o_src_mac,
   output logic [63:0] o_time_stamp,
   output logic [63:0] o_delay,
   output logic        o_frame_err,
   output logic [15:0] o_rx_frame_cnt
);

   localparam logic [2:0] LAST_BEAT = 3'(FRAME_BEATS - 1);
   localparam logic [2:0] PAY_FIRST = 3'd2;

   ctrl_state_e state_q, state_d;
   logic [2:0]  beat_q, beat_d;
   logic        bad_q, bad_d;
   logic        ok_d, err_d;
   logic        beat_bad, hdr_mine;

   // staging registers for the frame in flight
   logic [47:0] src_q;
   logic [15:0] dst_hi_q;
   logic        slot_q;
   logic        is_slot_q;
   logic [63:0] ts_q;
   logic [15:0] cnt_q;

   logic [47:0] hdr_dest;
   logic [15:0] hdr_type;

   assign hdr_dest = {dst_hi_q, i_rx_axis_tdata[63:32]};
   assign hdr_type = i_rx_axis_tdata[31:16];
   assign hdr_mine = (hdr_dest == P_MY_MAC) &&
                     ((hdr_type == P_SLOT_ID_TYPE) || (hdr_type == P_SIM_START));
   // a short beat anywhere, or an errored last beat, spoils the frame
   assign beat_bad = (i_rx_axis_tkeep != KEEP_ALL) ||
                     (i_rx_axis_tlast && i_rx_axis_tuser);

   // state register and frame-progress tracking
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         beat_q  <= '0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         bad_q   <= bad_d;
      end
   end

   // next state, frame verdict (ok / err) on the closing beat
   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      bad_d   = bad_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      if (i_rx_axis_tvalid) begin
         case (state_q)
            ST_IDLE: begin
               bad_d = beat_bad;
               if (i_rx_axis_tlast) err_d   = 1'b1;
               else                 state_d = ST_HDR;
            end
            ST_HDR: begin
               bad_d = bad_q | beat_bad;
               if (!hdr_mine) begin
                  // not for us: silently skip the rest
                  state_d = i_rx_axis_tlast ? ST_IDLE : ST_DROP;
               end else if (i_rx_axis_tlast) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_PAYLOAD;
                  beat_d  = PAY_FIRST;
               end
            end
            ST_PAYLOAD: begin
               bad_d = bad_q | beat_bad;
               if (beat_q == LAST_BEAT) begin
                  if (i_rx_axis_tlast) begin
                     state_d = ST_IDLE;
                     if (bad_d) err_d = 1'b1;
                     else       ok_d  = 1'b1;
                  end else begin
                     // overlong frame: flag once, then drain to tlast
                     err_d   = 1'b1;
                     state_d = ST_DROP;
                  end
               end else if (i_rx_axis_tlast) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  beat_d = beat_q + 3'd1;
               end
            end
            ST_DROP: begin
               if (i_rx_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // capture header and timestamp fields as their beats go by
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         src_q     <= '0;
         dst_hi_q  <= '0;
         slot_q    <= 1'b0;
         is_slot_q <= 1'b0;
         ts_q      <= '0;
      end else if (i_rx_axis_tvalid) begin
         case (state_q)
            ST_IDLE: begin
               src_q    <= i_rx_axis_tdata[63:16];
               dst_hi_q <= i_rx_axis_tdata[15:0];
            end
            ST_HDR: begin
               slot_q    <= i_rx_axis_tdata[0];
               is_slot_q <= (hdr_type == P_SLOT_ID_TYPE);
            end
            ST_PAYLOAD: begin
               if (beat_q == PAY_FIRST) ts_q <= i_rx_axis_tdata;
            end
            default: ;
         endcase
      end
   end

   // publish results one cycle after the closing beat
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_new_slot_start <= 1'b0;
         o_sim_start      <= 1'b0;
         o_frame_err      <= 1'b0;
         o_slot_id        <= 1'b0;
         o_src_mac        <= '0;
         o_time_stamp     <= '0;
         cnt_q            <= '0;
      end else begin
         o_new_slot_start <= ok_d &  is_slot_q;
         o_sim_start      <= ok_d & ~is_slot_q;
         o_frame_err      <= err_d;
         if (ok_d) begin
            o_slot_id    <= slot_q;
            o_src_mac    <= src_q;
            o_time_stamp <= ts_q;
            cnt_q        <= cnt_q + 16'd1;
         end
      end
   end

   assign o_rx_frame_cnt = cnt_q;

`ifdef CTRL_RX_DELAY_EN
   // one-way delay: local arrival time minus remote send time, mod 2^64
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)  o_delay <= '0;
      else if (ok_d) o_delay <= i_local_time - ts_q;
   end
`else
   logic unused_local_time;
   assign unused_local_time = ^i_local_time;
   assign o_delay = '0;
`endif

endmodule

// File: tb/tb_ctrl_rx.sv
// Scoreboard bench for ctrl_rx: frames are generated from a high-level
// description, the expected outcome is queued at issue time and a monitor
// compares every pulse the DUT produces against the queue head.
module tb_ctrl_rx;

   localparam logic [47:0] MY   = 48'h8D_BC_5C_4A_00_00;
   localparam logic [15:0] TSLT = 16'hff03;
   localparam logic [15:0] TSIM = 16'hff0a;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_rx_axis_tvalid = 1'b0;
   logic [63:0] i_rx_axis_tdata = '0;
   logic        i_rx_axis_tlast = 1'b0;
   logic [7:0]  i_rx_axis_tkeep = 8'hff;
   logic        i_rx_axis_tuser = 1'b0;
   logic [63:0] i_local_time = '0;
   logic        o_new_slot_start, o_sim_start, o_slot_id, o_frame_err;
   logic [47:0] o_src_mac;
   logic [63:0] o_time_stamp, o_delay;
   logic [15:0] o_rx_frame_cnt;

   always #5 i_clk = ~i_clk;

   ctrl_rx dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n),
      .i_rx_axis_tvalid(i_rx_axis_tvalid), .i_rx_axis_tdata(i_rx_axis_tdata),
      .i_rx_axis_tlast(i_rx_axis_tlast), .i_rx_axis_tkeep(i_rx_axis_tkeep),
      .i_rx_axis_tuser(i_rx_axis_tuser), .i_local_time(i_local_time),
      .o_new_slot_start(o_new_slot_start), .o_sim_start(o_sim_start),
      .o_slot_id(o_slot_id), .o_src_mac(o_src_mac), .o_time_stamp(o_time_stamp),
      .o_delay(o_delay), .o_frame_err(o_frame_err), .o_rx_frame_cnt(o_rx_frame_cnt)
   );

   typedef struct {
      bit          ns, ss, er;
      bit          slot;
      logic [47:0] src;
      logic [63:0] ts, dly;
      logic [15:0] cnt;
   } exp_t;

   exp_t q[$];
   exp_t m;          // published state of the last valid frame
   int   n_chk = 0, n_fail = 0;
   bit   gaps = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      m.ns = 0; m.ss = 0; m.er = 0; m.slot = 0;
      m.src = '0; m.ts = '0; m.dly = '0; m.cnt = '0;
   endtask

   // monitor: every pulse must match the oldest pending expectation
   always @(negedge i_clk) begin
      exp_t e;
      if (i_rst_n && (o_new_slot_start || o_sim_start || o_frame_err)) begin
         if (q.size() == 0) begin
            chk("unexpected_pulse", {61'd0, o_new_slot_start, o_sim_start, o_frame_err}, 64'd0);
         end else begin
            e = q.pop_front();
            chk("pulse_kind", {61'd0, o_new_slot_start, o_sim_start, o_frame_err},
                {61'd0, e.ns, e.ss, e.er});
            chk("slot_id", {63'd0, o_slot_id}, {63'd0, e.slot});
            chk("src_mac", {16'd0, o_src_mac}, {16'd0, e.src});
            chk("time_stamp", o_time_stamp, e.ts);
            chk("delay", o_delay, e.dly);
            chk("frame_cnt", {48'd0, o_rx_frame_cnt}, {48'd0, e.cnt});
         end
      end
   end

   task automatic idle(input int n);
      i_rx_axis_tvalid = 0;
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic beat(input logic [63:0] d, input bit l, input logic [7:0] k,
                       input bit u, input logic [63:0] lt);
      if (gaps && $urandom_range(0, 3) == 0) begin
         i_rx_axis_tvalid = 0;
         i_rx_axis_tdata  = {$urandom, $urandom};
         i_rx_axis_tlast  = $urandom_range(0, 1);
         idle($urandom_range(1, 2));
      end
      i_rx_axis_tvalid = 1;
      i_rx_axis_tdata  = d;
      i_rx_axis_tlast  = l;
      i_rx_axis_tkeep  = k;
      i_rx_axis_tuser  = u;
      i_local_time     = lt;
      @(posedge i_clk);
      #1;
      i_rx_axis_tvalid = 0;
      i_rx_axis_tlast  = 0;
      i_rx_axis_tkeep  = 8'hff;
      i_rx_axis_tuser  = 0;
   endtask

   task automatic reset_check();
      i_rx_axis_tvalid = 0;
      i_rst_n = 0;
      repeat (2) @(posedge i_clk);
      #1;
      chk("rst_new_slot", {63'd0, o_new_slot_start}, 64'd0);
      chk("rst_sim_start", {63'd0, o_sim_start}, 64'd0);
      chk("rst_frame_err", {63'd0, o_frame_err}, 64'd0);
      chk("rst_slot_id", {63'd0, o_slot_id}, 64'd0);
      chk("rst_src_mac", {16'd0, o_src_mac}, 64'd0);
      chk("rst_time_stamp", o_time_stamp, 64'd0);
      chk("rst_delay", o_delay, 64'd0);
      chk("rst_cnt", {48'd0, o_rx_frame_cnt}, 64'd0);
      i_rst_n = 1;
      model_clear();
   endtask

   // last_at: beat index carrying tlast; keep_bad: beat with tkeep=0f (-1 none);
   // rst_at: beat index at which reset hits instead (-1 none)
   task automatic frame(input logic [47:0] dest, input logic [15:0] typ, input bit slot,
                        input logic [63:0] ts, input logic [63:0] lt, input int last_at,
                        input int keep_bad, input bit tuser_last, input int rst_at);
      logic [47:0] src;
      logic [63:0] d;
      bit          mine;
      exp_t        e;
      src  = 48'({$urandom, $urandom});
      mine = (dest == MY) && (typ == TSLT || typ == TSIM);
      if (rst_at < 0) begin
         e = m; e.ns = 0; e.ss = 0; e.er = 0;
         if (last_at == 0) begin
            e.er = 1; q.push_back(e);
         end else if (!mine) begin
            // addressed elsewhere or unknown type: silently dropped
         end else if (last_at != 7 || (keep_bad >= 0 && keep_bad <= 7) || tuser_last) begin
            e.er = 1; q.push_back(e);
         end else begin
            m.slot = slot; m.src = src; m.ts = ts;
`ifdef CTRL_RX_DELAY_EN
            m.dly = lt - ts;
`else
            m.dly = '0;
`endif
            m.cnt = m.cnt + 16'd1;
            e = m; e.ns = (typ == TSLT); e.ss = (typ != TSLT); e.er = 0;
            q.push_back(e);
         end
      end
      for (int b = 0; b <= last_at; b++) begin
         if (b == rst_at) begin
            reset_check();
            return;
         end
         case (b)
            0:       d = {src, dest[47:32]};
            1:       d = {dest[31:0], typ, 15'($urandom), slot};
            2:       d = ts;
            default: d = {$urandom, $urandom};
         endcase
         beat(d, b == last_at, (b == keep_bad) ? 8'h0f : 8'hff,
              (b == last_at) && tuser_last,
              (b == last_at) ? lt : {$urandom, $urandom});
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      logic [47:0] dest;
      logic [15:0] typ;
      int          last_at, keep_bad, r;
      model_clear();
      repeat (2) @(posedge i_clk);
      #1;
      reset_check();
      idle(2);

      // basic slot-ID and sim-start frames
      frame(MY, TSLT, 1, 64'h100, 64'h180, 7, -1, 0, -1);
      idle(2);
      frame(MY, TSIM, 0, 64'h2000, 64'h2345, 7, -1, 0, -1);
      idle(2);
      // wrong destination, then a valid frame back-to-back
      frame({MY[47:8], 8'h01}, TSLT, 1, 64'h5, 64'h9, 7, -1, 0, -1);
      frame(MY, TSLT, 0, 64'h300, 64'h310, 7, -1, 0, -1);
      // unknown type dropped
      frame(MY, 16'h0800, 1, 64'h1, 64'h2, 7, -1, 0, -1);
      idle(2);
      // early tlast, missing tlast, then recovery
      frame(MY, TSLT, 1, 64'h11, 64'h22, 5, -1, 0, -1);
      frame(MY, TSIM, 1, 64'h33, 64'h44, 9, -1, 0, -1);
      frame(MY, TSLT, 1, 64'h55, 64'h66, 7, -1, 0, -1);
      // single-beat frame, tuser on last beat, short tkeep
      frame(MY, TSLT, 1, 64'h77, 64'h88, 0, -1, 0, -1);
      frame(MY, TSLT, 0, 64'h99, 64'haa, 7, -1, 1, -1);
      frame(MY, TSIM, 1, 64'hbb, 64'hcc, 7, 3, 0, -1);
      idle(3);
      // reset mid-frame, then a valid frame
      frame(MY, TSLT, 1, 64'hdead, 64'hbeef, 7, -1, 0, 4);
      frame(MY, TSIM, 1, 64'hf00, 64'hf80, 7, -1, 0, -1);
      idle(3);
      // counter wrap
      force dut.cnt_q = 16'hffff;
      idle(1);
      release dut.cnt_q;
      m.cnt = 16'hffff;
      frame(MY, TSLT, 1, 64'hffff_ffff_ffff_fff0, 64'h10, 7, -1, 0, -1);
      frame(MY, TSLT, 0, 64'h1234, 64'h1000, 7, -1, 0, -1);
      idle(2);

      // randomized traffic with mid-frame tvalid gaps
      gaps = 1;
      for (int i = 0; i < 250; i++) begin
         r = $urandom_range(0, 99);
         if (r < 80)      dest = MY;
         else if (r < 90) dest = MY ^ 48'h1;
         else             dest = 48'({$urandom, $urandom});
         r = $urandom_range(0, 99);
         if (r < 45)      typ = TSLT;
         else if (r < 90) typ = TSIM;
         else             typ = 16'($urandom);
         last_at  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 10) : 7;
         keep_bad = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
         frame(dest, typ, 1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
               last_at, keep_bad, $urandom_range(0, 11) == 0, -1);
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      end
      gaps = 0;
      idle(5);
      chk("queue_empty", 64'(q.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
